// File: rtl/ram_bist_ctrl.sv
// RAM self-test sequencer: fills every location with (2*k) mod 2**DATA_W, then reads back
// LFSR-chosen addresses and reports errors. Define RAM_BIST_ERR_INJECT_EN for fill fault injection.
module ram_bist_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int NUM_CHECKS = 20,
  parameter int LFSR_SEED  = 35,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef RAM_BIST_ERR_INJECT_EN
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
`endif
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              chk_valid,
  output logic [ADDR_W-1:0] chk_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  output logic              ram_sel,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, FILL, CHK_ADDR, CHK_WAIT, CHK_CMP, DONE} state_t;

  localparam logic [15:0]       SEED      = (16'(LFSR_SEED) == 16'd0) ? 16'd1 : 16'(LFSR_SEED);
  localparam int                WAIT_N    = (RD_LAT >= 2) ? RD_LAT - 2 : 0;
  localparam logic [7:0]        LAST_CHK  = 8'(NUM_CHECKS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] addr_q, fill_d, fail_q;
  logic [DATA_W-1:0] din_q, din_d, din_first;
  logic [7:0]        chk_cnt_q, err_q;
  logic [1:0]        wait_q;
  logic              busy_q, done_q, pass_q, chk_valid_q, we_q, sel_q;
  logic              mismatch, inj_first, inj_next;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [ADDR_W+DATA_W:0] t;
    t = {{DATA_W{1'b0}}, a, 1'b0};
    return t[DATA_W-1:0];
  endfunction

`ifdef RAM_BIST_ERR_INJECT_EN
  logic              inj_en_q;
  logic [ADDR_W-1:0] inj_addr_q;
  assign inj_first = inj_en && (inj_addr == '0);
  assign inj_next  = inj_en_q && (inj_addr_q == fill_d);
`else
  assign inj_first = 1'b0;
  assign inj_next  = 1'b0;
`endif

  // Galois right-shift LFSR, taps 0xB400
  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign fill_d    = addr_q + 1'b1;
  assign din_d     = pat(fill_d) ^ {{(DATA_W-1){1'b0}}, inj_next};
  assign din_first = pat('0) ^ {{(DATA_W-1){1'b0}}, inj_first};
  assign mismatch  = (ram_dout != pat(addr_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      addr_q      <= '0;
      din_q       <= '0;
      fail_q      <= '0;
      chk_cnt_q   <= '0;
      err_q       <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      chk_valid_q <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 1'b0;
`ifdef RAM_BIST_ERR_INJECT_EN
      inj_en_q    <= 1'b0;
      inj_addr_q  <= '0;
`endif
    end else begin
      chk_valid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q   <= FILL;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          pass_q    <= 1'b0;
          err_q     <= '0;
          fail_q    <= '0;
          lfsr_q    <= SEED;
          chk_cnt_q <= '0;
          sel_q     <= 1'b1;
          we_q      <= 1'b1;
          addr_q    <= '0;
          din_q     <= din_first;
`ifdef RAM_BIST_ERR_INJECT_EN
          inj_en_q   <= inj_en;
          inj_addr_q <= inj_addr;
`endif
        end
        FILL: if (addr_q == LAST_ADDR) begin
          we_q        <= 1'b0;
          din_q       <= '0;
          lfsr_q      <= lfsr_d;
          addr_q      <= lfsr_d[ADDR_W-1:0];
          state_q     <= (RD_LAT == 0) ? CHK_CMP : CHK_ADDR;
          chk_valid_q <= (RD_LAT == 0);
        end else begin
          addr_q <= fill_d;
          din_q  <= din_d;
        end
        CHK_ADDR: if (RD_LAT == 1) begin
          state_q     <= CHK_CMP;
          chk_valid_q <= 1'b1;
        end else begin
          state_q <= CHK_WAIT;
          wait_q  <= 2'(WAIT_N);
        end
        CHK_WAIT: if (wait_q == 2'd0) begin
          state_q     <= CHK_CMP;
          chk_valid_q <= 1'b1;
        end else begin
          wait_q <= wait_q - 2'd1;
        end
        CHK_CMP: begin
          // err_q==0 marks the first mismatch; once saturated it never returns to 0
          if (mismatch) begin
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            if (err_q == 8'd0)  fail_q <= addr_q;
          end
          if (chk_cnt_q == LAST_CHK) begin
            state_q <= DONE;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == 8'd0) && !mismatch;
          end else begin
            chk_cnt_q   <= chk_cnt_q + 8'd1;
            lfsr_q      <= lfsr_d;
            addr_q      <= lfsr_d[ADDR_W-1:0];
            state_q     <= (RD_LAT == 0) ? CHK_CMP : CHK_ADDR;
            chk_valid_q <= (RD_LAT == 0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_addr = fail_q;
  assign chk_valid = chk_valid_q;
  assign chk_addr  = addr_q;
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
  assign ram_we    = we_q;
  assign ram_sel   = sel_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: four instances (read latencies 1,1,0,3) each with a model RAM,
// checked against an address-list reference model; exercises RAM_BIST_ERR_INJECT_EN if defined.
module tb_ram_bist_ctrl;

  localparam int NI = 4;
  localparam int LATS [NI] = '{1, 1, 0, 3};
  localparam int CHKS [NI] = '{20, 255, 20, 20};

  logic       clk = 1'b0;
  logic       rst, start;
  logic       inj_en = 1'b0;
  logic [9:0] inj_addr = '0;

  logic       busy [NI], done [NI], pass [NI], chk_valid [NI], ram_we [NI], ram_sel [NI];
  logic [7:0] err_count [NI], ram_din [NI], ram_dout [NI];
  logic [9:0] fail_addr [NI], chk_addr [NI], ram_addr [NI];

  int total = 0, bad = 0, cyc = 0, t0 = 0, run_id = 0;
  int addrs [256];
  bit bad_loc [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(input int inst, input int a);
    return (inst == 1 && bad_loc[a]) || (inj_en && a == int'(inj_addr));
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    logic [7:0] mem [1024];
    logic [7:0] pipe [4];
    logic [7:0] rd;

    ram_bist_ctrl #(.ADDR_W(10), .DATA_W(8), .NUM_CHECKS(CHKS[gi]), .LFSR_SEED(35), .RD_LAT(LATS[gi])) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef RAM_BIST_ERR_INJECT_EN
      .inj_en(inj_en), .inj_addr(inj_addr),
`endif
      .busy(busy[gi]), .done(done[gi]), .pass(pass[gi]), .err_count(err_count[gi]),
      .fail_addr(fail_addr[gi]), .chk_valid(chk_valid[gi]), .chk_addr(chk_addr[gi]),
      .ram_addr(ram_addr[gi]), .ram_din(ram_din[gi]), .ram_we(ram_we[gi]),
      .ram_sel(ram_sel[gi]), .ram_dout(ram_dout[gi])
    );

    // model RAM; instance 1 has bit 0 stuck at 1 wherever bad_loc is set
    always_comb begin
      rd = mem[ram_addr[gi]];
      if (gi == 1 && bad_loc[ram_addr[gi]]) rd[0] = 1'b1;
    end
    always @(posedge clk) begin
      if (ram_sel[gi] && ram_we[gi]) mem[ram_addr[gi]] <= ram_din[gi];
      pipe[0] <= rd;
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end
    if (LATS[gi] == 0) begin : comb_rd
      assign ram_dout[gi] = rd;
    end else begin : pipe_rd
      assign ram_dout[gi] = pipe[LATS[gi]-1];
    end

    // scoreboard: fill sequence, compare addresses, and end-of-run results
    initial begin
      int fk, cj, my_id, hits, first;
      bit dprev;
      fk = 0; cj = 0; my_id = 0; dprev = 1'b0;
      forever begin
        @(negedge clk);
        if (my_id != run_id) begin
          my_id = run_id; fk = 0; cj = 0; dprev = 1'b1;
        end
        if (ram_we[gi]) begin
          chk("fill_addr", int'(ram_addr[gi]), fk);
          chk("fill_din", int'(ram_din[gi]), ((2 * fk) % 256) ^ ((inj_en && fk == int'(inj_addr)) ? 1 : 0));
          chk("fill_sel", int'(ram_sel[gi]), 1);
          fk++;
        end else begin
          chk("din_zero", int'(ram_din[gi]), 0);
        end
        if (chk_valid[gi]) begin
          chk("chk_addr", int'(chk_addr[gi]), (cj < 256) ? addrs[cj] : -1);
          chk("chk_hold", int'(ram_addr[gi]), int'(chk_addr[gi]));
          cj++;
        end
        if (done[gi] && !dprev) begin
          hits = 0; first = 0;
          for (int j = 0; j < CHKS[gi]; j++)
            if (is_bad(gi, addrs[j])) begin
              if (hits == 0) first = addrs[j];
              hits++;
            end
          chk("done_cycle", cyc - t0, 1024 + CHKS[gi] * (LATS[gi] + 1) + 1);
          chk("fill_count", fk, 1024);
          chk("chk_count", cj, CHKS[gi]);
          chk("pass", int'(pass[gi]), int'(hits == 0));
          chk("err_count", int'(err_count[gi]), (hits > 255) ? 255 : hits);
          chk("fail_addr", int'(fail_addr[gi]), first);
          chk("done_busy", int'(busy[gi]), 0);
          chk("done_sel", int'(ram_sel[gi]), 0);
        end
        dprev = done[gi];
      end
    end
  end

  task automatic do_run(input bit extra_start);
    bit all;
    int n;
    @(negedge clk);
    t0 = cyc; run_id++; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("start_busy", int'(busy[i]), 1);
      chk("start_done", int'(done[i]), 0);
    end
    if (extra_start) begin
      repeat ($urandom_range(2, 900)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0; all = 1'b0;
    while (!all && n < 3000) begin
      @(negedge clk);
      n++;
      all = 1'b1;
      for (int i = 0; i < NI; i++) if (!done[i]) all = 1'b0;
    end
    chk("run_timeout", int'(all), 1);
  endtask

  initial begin
    int l, j1, j2;
    l = 35;
    for (int j = 0; j < 256; j++) begin
      l = (l >> 1) ^ (((l & 1) != 0) ? 'hB400 : 0);
      addrs[j] = l % 1024;
    end
    for (int a = 0; a < 1024; a++) bad_loc[a] = 1'b0;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_pass", int'(pass[i]), 0);
      chk("rst_err", int'(err_count[i]), 0);
      chk("rst_fail", int'(fail_addr[i]), 0);
      chk("rst_chkv", int'(chk_valid[i]), 0);
      chk("rst_we", int'(ram_we[i]), 0);
      chk("rst_sel", int'(ram_sel[i]), 0);
      chk("rst_addr", int'(ram_addr[i]), 0);
      chk("rst_din", int'(ram_din[i]), 0);
    end
    rst = 1'b0;

    // stuck bit at 300 on instance 1, plus an ignored start while busy
    bad_loc[300] = 1'b1;
    do_run(1'b1);

    // restart from DONE with two random stuck locations taken from the check list
    bad_loc[300] = 1'b0;
    j1 = $urandom_range(0, 254);
    j2 = $urandom_range(0, 254);
    bad_loc[addrs[j1]] = 1'b1;
    bad_loc[addrs[j2]] = 1'b1;
    do_run(1'b0);
    for (int a = 0; a < 1024; a++) bad_loc[a] = 1'b0;

    // reset in the middle of the fill, then a clean run
    @(negedge clk);
    t0 = cyc; run_id++; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat ($urandom_range(2, 1000)) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("abort_we", int'(ram_we[i]), 0);
      chk("abort_busy", int'(busy[i]), 0);
      chk("abort_done", int'(done[i]), 0);
      chk("abort_sel", int'(ram_sel[i]), 0);
    end
    do_run(1'b0);

`ifdef RAM_BIST_ERR_INJECT_EN
    inj_en = 1'b1; inj_addr = 10'(addrs[0]);
    do_run(1'b0);
    chk("inj_err0", int'(err_count[0]), 1);
    chk("inj_fail0", int'(fail_addr[0]), addrs[0]);
    inj_en = 1'b0;
    do_run(1'b0);
    chk("noinj_pass0", int'(pass[0]), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
